pin_bus_responder: RTL
======================

// Module: pin_bus_responder
// PURPOSE
//  Design-side responder for the byte-wide pin command protocol driven by the cocotb bench through ui_in/uio_in.
//  The host presents a byte and raises a strobe. The block captures the byte and answers with ack and, for reads, rd_data.
//  Provides a small register file (NUM_REGS x 8) to the rest of tt_um_* logic.
//  Four-phase req/ack handshake; strobe is treated as asynchronous and synchronised internally.
// PARAMETERS
//  NUM_REGS     8    number of 8-bit registers; ADDR_W = $clog2(NUM_REGS)
//  SYNC_STAGES  2    strobe synchroniser depth (>=2)
//  TIMEOUT      255  max cycles in WAIT_DATA before abort; counter width = $clog2(TIMEOUT+1)
// PORTS
//  clk       in   1              system clock
//  rst       in   1              asynchronous, active-high reset
//  cmd_byte  in   8              host byte (ui_in); held stable by host from strb rise until ack rise
//  strb      in   1              host request (uio_in[0]); four-phase
//  ack       out  1              responder acknowledge (uio_out[1])
//  rd_data   out  8              read data (uo_out); valid while ack high after a read command
//  err       out  1              sticky: write-data timeout occurred
//  regs_flat out  8*NUM_REGS     register file contents; reg i at [8*i+7:8*i]
// BEHAVIOUR
//  Reset: rst is async, active-high. All regs=0, ack=0, rd_data=0, err=0, state=IDLE, timeout cnt=0.
//    Synchroniser and edge-history flops reset to 1, so a strb held high across reset gives no spurious edge.
//  Command byte: [7]=W (1 write, 0 read), [6]=CLR (clear err), [ADDR_W-1:0]=addr; remaining bits ignored.
//    Addresses >= NUM_REGS: reads return 8'h00; writes are dropped. The handshake still completes.
//  Edge detect: rise = sync_out & ~prev. If strb is first sampled high at edge k, the FSM acts at edge k+SYNC_STAGES.
//    It captures cmd_byte at that edge, and ack is registered high at that same edge.
//  FSM states: IDLE, CMD_ACK, WAIT_DATA, DATA_ACK.
//   IDLE, on rise:
//     - if CLR, err<=0.
//     - read: rd_data<=reg[addr], ack<=1, go CMD_ACK (ret=IDLE).
//     - write: latch addr, ack<=1, go CMD_ACK (ret=WAIT_DATA).
//   CMD_ACK: when synced strb==0, ack<=0 and go to ret. Rises cannot occur here (strb is high).
//   WAIT_DATA: cnt increments each cycle.
//     - on rise: reg[addr]<=cmd_byte, ack<=1, cnt<=0, go DATA_ACK.
//     - if cnt==TIMEOUT with no rise: err<=1, cnt<=0, go IDLE, no write.
//     - timeout and rise on the same cycle: the rise wins.
//   DATA_ACK: when synced strb==0, ack<=0 and go IDLE.
//  rd_data holds its last value until the next read. It is not cleared on writes.
//  Ack latency: ack rises SYNC_STAGES cycles after strb is first sampled high; ack falls SYNC_STAGES cycles after strb falls.
//  A rise seen in any state other than IDLE/WAIT_DATA is ignored (protocol violation; no state change).
//  Reset mid-transaction: the transaction is aborted and no partial write occurs. The host must drop strb and restart.
//  regs_flat is driven directly from the registers; a write is visible the cycle after the DATA_ACK entry edge.
// STRUCTURE
//  pin_bus_defs.vh holds the shared constants:
//    - state encodings (2-bit);
//    - command bit positions CMD_W_BIT=7, CMD_CLR_BIT=6.
//  Sub-module sync_rise_detect (params STAGES, RESET_VAL): outputs level + one-cycle rise + fall pulses.
//  The top holds the FSM, timeout counter and register array.
// TESTING
//  1. Write 0x5A to addr 3 (cmd 0x83, then data 0x5A, full handshakes), then read (cmd 0x03) -> rd_data=0x5A; regs_flat[31:24]=0x5A.
//  2. Latency: strb high at edge k -> ack high after edge k+2 (SYNC_STAGES=2); strb low -> ack low 2 edges later; rd_data stable while ack high.
//  3. Timeout: cmd 0x81, then no data strobe for 256 cycles -> err=1, state IDLE, reg1 unchanged. Next cmd 0x40 (read addr0 with CLR) -> err=0.
//  4. Out-of-range: NUM_REGS=6, write cmd 0x87 data 0xFF -> all regs unchanged, ack still cycles; read 0x07 -> rd_data=0x00.
//  5. Reset mid-write: after cmd 0x82 ack, assert rst with strb high -> all outputs 0 immediately. Release rst with strb still high -> no ack. Drop strb, redo -> normal.
//  6. Back-to-back: 8 write/read pairs at minimum handshake spacing, addresses 0..7 -> every readback matches; no missed or duplicated acks.

Source files
------------

// File: rtl/pin_bus_responder_pkg.sv
// Shared constants for the pin bus responder: FSM encodings, command bit
// positions and the command address decode helper.
package pin_bus_responder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_CMD_ACK   = 2'd1;
  localparam state_t ST_WAIT_DATA = 2'd2;
  localparam state_t ST_DATA_ACK  = 2'd3;

  localparam int CMD_W_BIT   = 7;
  localparam int CMD_CLR_BIT = 6;

  // Keeps only the low addr_w bits of a command byte; the rest are don't-care.
  function automatic logic [7:0] cmd_addr(input logic [7:0] b, input int unsigned addr_w);
    logic [7:0] mask;
    mask = 8'hFF >> (32'd8 - addr_w);
    return b & mask;
  endfunction

endpackage

// File: rtl/pin_bus_responder_sync_rise_detect.sv
// Multi-stage synchroniser for an asynchronous level, with one-cycle rise and
// fall pulses derived from the synchronised level.
module sync_rise_detect #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  // Next-state of the shift chain and edge history.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  // Chain and history reset high so a strobe held across reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/pin_bus_responder.sv
// Byte-wide four-phase command responder: decodes read/write commands from the
// host, answers with ack/rd_data and exposes a small register file.
module pin_bus_responder
  import pin_bus_responder_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            cmd_byte,
  input  logic                  strb,
  output logic                  ack,
  output logic [7:0]            rd_data,
  output logic                  err,
  output logic [8*NUM_REGS-1:0] regs_flat
);

  localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  logic             level_s;
  logic             rise_s;
  logic             fall_s;
  logic             release_s;
  logic [7:0]       cmd_addr_s;
  logic [7:0]       rd_sel_s;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic             ack_q, ack_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       regs_q [NUM_REGS];
  logic [7:0]       regs_d [NUM_REGS];

  sync_rise_detect #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_strb_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (strb),
    .level (level_s),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  assign cmd_addr_s = cmd_addr(cmd_byte, ADDR_W);
  // The falling pulse coincides with the first low level seen in an ack state.
  assign release_s  = fall_s | ~level_s;

  // Read mux; unmatched (out-of-range) addresses read as zero.
  always_comb begin
    rd_sel_s = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_addr_s == 8'(i)) begin
        rd_sel_s = regs_q[i];
      end else begin
        rd_sel_s = rd_sel_s;
      end
    end
  end

  // Handshake FSM, timeout counter and register-file write path.
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    ack_d     = ack_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    regs_d    = regs_q;

    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          if (cmd_byte[CMD_CLR_BIT]) begin
            err_d = 1'b0;
          end else begin
            err_d = err_q;
          end
          if (cmd_byte[CMD_W_BIT]) begin
            addr_d = cmd_addr_s;
            ret_d  = ST_WAIT_DATA;
          end else begin
            rd_data_d = rd_sel_s;
            ret_d     = ST_IDLE;
          end
          ack_d   = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_CMD_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CMD_ACK: begin
        if (release_s) begin
          ack_d   = 1'b0;
          state_d = ret_q;
        end else begin
          state_d = ST_CMD_ACK;
        end
      end

      ST_WAIT_DATA: begin
        // A data strobe beats a timeout landing on the same cycle.
        if (rise_s) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == 8'(i)) begin
              regs_d[i] = cmd_byte;
            end else begin
              regs_d[i] = regs_q[i];
            end
          end
          ack_d   = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_DATA_ACK;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA_ACK: begin
        if (release_s) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA_ACK;
        end
      end

      default: begin
        ack_d   = 1'b0;
        cnt_d   = {CNT_W{1'b0}};
        ret_d   = ST_IDLE;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ret_q     <= ST_IDLE;
      ack_q     <= 1'b0;
      rd_data_q <= 8'h00;
      err_q     <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      addr_q    <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      ack_q     <= ack_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign ack     = ack_q;
  assign rd_data = rd_data_q;
  assign err     = err_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs_q[g];
  end

endmodule
